lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/lsu_if.sv | 42 ++++
 rtl/lsu.sv | 161 ++++++++++++++++
 tb/tb_lsu.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - execute-to-LSU request, data-bus and writeback signal bundle
// slave: LSU side; master: pipeline/bus side driving requests and bus responses.
interface lsu_if;
  logic        in_valid;
  logic [31:0] memAddr;
  logic [31:0] memData;
  logic        readWr;
  logic        writeWr;
  logic [3:0]  rmask;
  logic [3:0]  wmask;
  logic        load_signed;
  logic [31:0] regcData;
  logic [4:0]  regcAddr;
  logic        regcWr;
  logic        stall_o;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_addr;
  logic        wb_wr;
  logic [1:0]  err_o;

  modport slave (
    input  in_valid, memAddr, memData, readWr, writeWr, rmask, wmask, load_signed,
           regcData, regcAddr, regcWr, dmem_rdata, dmem_ack,
    output stall_o, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
           wb_valid, wb_data, wb_addr, wb_wr, err_o
  );

  modport master (
    output in_valid, memAddr, memData, readWr, writeWr, rmask, wmask, load_signed,
           regcData, regcAddr, regcWr, dmem_rdata, dmem_ack,
    input  stall_o, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
           wb_valid, wb_data, wb_addr, wb_wr, err_o
  );
endinterface

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit: one outstanding data-bus access, registered writeback
// Optional macro LSU_MISALIGN_CHECK_EN traps misaligned half/word accesses (err_o=11).
module lsu (
  input logic  clk,
  input logic  rst,
  lsu_if.slave bus
);
  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  state_t      r_state, w_next;
  logic        r_req, r_we, r_is_load, r_signed, r_regc_wr;
  logic [31:0] r_addr, r_wdata, r_wb_data;
  logic [3:0]  r_wstrb;
  logic [1:0]  r_lo, r_size, r_err;
  logic [7:0]  r_cnt;
  logic        r_wb_valid, r_wb_wr;
  logic [4:0]  r_wb_addr;

  logic        w_mem_op, w_misalign, w_timeout;
  logic [3:0]  w_mask;
  logic [2:0]  w_ones;
  logic [1:0]  w_size;
  logic [31:0] w_store, w_shifted, w_load;

  assign w_mem_op = bus.in_valid && (bus.readWr || bus.writeWr);
  assign w_mask   = bus.readWr ? bus.rmask : bus.wmask;
  assign w_ones   = {2'b00, w_mask[0]} + {2'b00, w_mask[1]} + {2'b00, w_mask[2]} + {2'b00, w_mask[3]};
  // A word mask shifted by a nonzero offset loses lanes, so three or more lanes still means word.
  assign w_size   = (w_ones >= 3'd3) ? SZ_WORD : ((w_ones == 3'd2) ? SZ_HALF : SZ_BYTE);

`ifdef LSU_MISALIGN_CHECK_EN
  assign w_misalign = ((w_size == SZ_HALF) && bus.memAddr[0]) ||
                      ((w_size == SZ_WORD) && (bus.memAddr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  // Counter holds WAIT-cycles-minus-one, so this fires on the 255th WAIT cycle.
  assign w_timeout = (r_cnt == 8'd254) && !bus.dmem_ack;

  always_comb begin
    case (w_size)
      SZ_BYTE: w_store = {4{bus.memData[7:0]}};
      SZ_HALF: w_store = {2{bus.memData[15:0]}};
      default: w_store = bus.memData;
    endcase
  end

  assign w_shifted = bus.dmem_rdata >> {r_lo, 3'b000};

  always_comb begin
    case (r_size)
      SZ_BYTE: w_load = {{24{r_signed & w_shifted[7]}}, w_shifted[7:0]};
      SZ_HALF: w_load = {{16{r_signed & w_shifted[15]}}, w_shifted[15:0]};
      default: w_load = bus.dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    bus.stall_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_mem_op) begin
          bus.stall_o = 1'b1;
          if (!w_misalign) w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        bus.stall_o = 1'b1;
        if (bus.dmem_ack || w_timeout) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_lo       <= '0;
      r_size     <= SZ_BYTE;
      r_is_load  <= 1'b0;
      r_signed   <= 1'b0;
      r_regc_wr  <= 1'b0;
      r_cnt      <= '0;
      r_err      <= 2'b00;
      r_wb_valid <= 1'b0;
      r_wb_wr    <= 1'b0;
      r_wb_data  <= '0;
      r_wb_addr  <= '0;
    end else begin
      r_wb_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_wb_addr <= bus.regcAddr;
            if (!w_mem_op) begin
              r_wb_valid <= 1'b1;
              r_wb_data  <= bus.regcData;
              r_wb_wr    <= bus.regcWr;
            end else if (w_misalign) begin
              r_wb_valid <= 1'b1;
              r_wb_data  <= '0;
              r_wb_wr    <= 1'b0;
              r_err      <= r_err | 2'b11;
            end else begin
              r_req     <= 1'b1;
              r_we      <= !bus.readWr;
              r_addr    <= {bus.memAddr[31:2], 2'b00};
              r_wdata   <= w_store;
              r_wstrb   <= bus.readWr ? 4'b0000 : bus.wmask;
              r_lo      <= bus.memAddr[1:0];
              r_size    <= w_size;
              r_is_load <= bus.readWr;
              r_signed  <= bus.load_signed;
              r_regc_wr <= bus.regcWr;
              r_cnt     <= '0;
            end
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 8'd1;
          if (bus.dmem_ack || w_timeout) begin
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_wstrb    <= 4'b0000;
            r_wb_valid <= 1'b1;
            r_wb_data  <= (bus.dmem_ack && r_is_load) ? w_load : 32'd0;
            r_wb_wr    <= bus.dmem_ack && r_is_load && r_regc_wr;
            if (!bus.dmem_ack) r_err <= r_err | 2'b01;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.dmem_req   = r_req;
  assign bus.dmem_we    = r_we;
  assign bus.dmem_addr  = r_addr;
  assign bus.dmem_wdata = r_wdata;
  assign bus.dmem_wstrb = r_wstrb;
  assign bus.wb_valid   = r_wb_valid;
  assign bus.wb_data    = r_wb_data;
  assign bus.wb_addr    = r_wb_addr;
  assign bus.wb_wr      = r_wb_wr;
  assign bus.err_o      = r_err;
endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - table-driven and randomized checks of lsu against a byte-lane model
`timescale 1ns/1ps
module tb_lsu;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lsu_if bus();
  lsu dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rd, wr, sgn;
    logic [1:0]  sz;
    logic [31:0] addr, data, rdata;
    int          delay;
    logic [4:0]  rc_addr;
    logic        rc_wr;
    logic [31:0] rc_data;
    logic [31:0] exp_wb;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] mask_for(input logic [1:0] sz, input logic [1:0] lo);
    case (sz)
      2'd0:    return 4'b0001 << lo;
      2'd1:    return 4'b0011 << lo;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lanes(input logic [3:0] strb);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) if (strb[i]) m[8*i +: 8] = 8'hFF;
    return m;
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] rdata, input logic [1:0] sz,
                                          input logic [1:0] lo, input logic sgn);
    longint lim, val;
    if (sz == 2'd2) return rdata;
    lim = longint'(1) << ((sz == 2'd0) ? 8 : 16);
    val = longint'(rdata >> (8 * lo)) % lim;
    if (sgn && (val >= lim / 2)) val = val - lim;
    return val[31:0];
  endfunction

  function automatic logic [31:0] place(input logic [31:0] data, input logic [1:0] sz,
                                        input logic [1:0] lo);
    if (sz == 2'd2) return data;
    return data << (8 * lo);
  endfunction

  function automatic vec_t mk(input logic rd, input logic wr, input logic sgn, input logic [1:0] sz,
                              input logic [31:0] addr, input logic [31:0] data,
                              input logic [31:0] rdata, input int delay, input logic [4:0] rc_addr,
                              input logic rc_wr, input logic [31:0] rc_data, input logic [31:0] exp_wb,
                              input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
    vec_t v;
    v.rd = rd; v.wr = wr; v.sgn = sgn; v.sz = sz; v.addr = addr; v.data = data; v.rdata = rdata;
    v.delay = delay; v.rc_addr = rc_addr; v.rc_wr = rc_wr; v.rc_data = rc_data;
    v.exp_wb = exp_wb; v.exp_strb = exp_strb; v.exp_wdata = exp_wdata;
    return v;
  endfunction

  task automatic idle_inputs();
    bus.in_valid = 1'b0; bus.readWr = 1'b0; bus.writeWr = 1'b0;
    bus.rmask = 4'b0; bus.wmask = 4'b0;
  endtask

  task automatic run_op(input vec_t v, input string tag);
    logic       mem;
    logic [3:0] m;
    int         stalls;
    mem = v.rd | v.wr;
    m = mask_for(v.sz, v.addr[1:0]);
    stalls = 0;
    bus.in_valid = 1'b1; bus.readWr = v.rd; bus.writeWr = v.wr;
    bus.memAddr = v.addr; bus.memData = v.data;
    bus.rmask = v.rd ? m : 4'b0; bus.wmask = v.wr ? m : 4'b0;
    bus.load_signed = v.sgn; bus.regcAddr = v.rc_addr; bus.regcWr = v.rc_wr; bus.regcData = v.rc_data;
    #1;
    chk({tag, " stall_accept"}, bus.stall_o, mem);
    if (bus.stall_o) stalls++;
    @(posedge clk); @(negedge clk);
    if (mem) begin
      for (int c = 1; c <= v.delay; c++) begin
        chk({tag, " dmem_req"}, bus.dmem_req, 1);
        chk({tag, " dmem_addr"}, bus.dmem_addr, v.addr & 32'hFFFF_FFFC);
        chk({tag, " dmem_we"}, bus.dmem_we, v.wr & ~v.rd);
        chk({tag, " dmem_wstrb"}, bus.dmem_wstrb, v.exp_strb);
        if (v.wr && !v.rd)
          chk({tag, " dmem_wdata"}, bus.dmem_wdata & lanes(v.exp_strb), v.exp_wdata & lanes(v.exp_strb));
        chk({tag, " wb_valid_wait"}, bus.wb_valid, 0);
        if (bus.stall_o) stalls++;
        if (c == v.delay) begin
          bus.dmem_ack = 1'b1;
          bus.dmem_rdata = v.rdata;
        end
        @(posedge clk); @(negedge clk);
      end
      bus.dmem_ack = 1'b0;
      chk({tag, " stall_cycles"}, stalls, 1 + v.delay);
    end
    idle_inputs();
    chk({tag, " wb_valid"}, bus.wb_valid, 1);
    chk({tag, " req_done"}, bus.dmem_req, 0);
    chk({tag, " wb_addr"}, bus.wb_addr, v.rc_addr);
    if (v.rd || !mem) begin
      chk({tag, " wb_data"}, bus.wb_data, v.exp_wb);
      chk({tag, " wb_wr"}, bus.wb_wr, v.rc_wr);
    end else begin
      chk({tag, " wb_wr_store"}, bus.wb_wr, 0);
    end
    @(posedge clk); @(negedge clk);
    chk({tag, " wb_pulse"}, bus.wb_valid, 0);
  endtask

  initial begin
    vec_t        tbl[$];
    vec_t        v;
    int          kind, n, seen;
    logic [1:0]  lo;
    logic [31:0] a;

    idle_inputs();
    bus.memAddr = '0; bus.memData = '0; bus.load_signed = 1'b0;
    bus.regcData = '0; bus.regcAddr = '0; bus.regcWr = 1'b0;
    bus.dmem_rdata = '0; bus.dmem_ack = 1'b0;

    #12;
    chk("rst dmem_req", bus.dmem_req, 0);
    chk("rst dmem_we", bus.dmem_we, 0);
    chk("rst dmem_wstrb", bus.dmem_wstrb, 0);
    chk("rst wb_valid", bus.wb_valid, 0);
    chk("rst wb_wr", bus.wb_wr, 0);
    chk("rst wb_data", bus.wb_data, 0);
    chk("rst wb_addr", bus.wb_addr, 0);
    chk("rst err_o", bus.err_o, 0);
    chk("rst stall_o", bus.stall_o, 0);
    @(negedge clk);
    rst = 1'b1;

    //        rd wr sg sz  addr          data          rdata         dly rca  rcw rcdata        exp_wb        strb     wdata
    tbl.push_back(mk(0, 0, 0, 2, 32'h0,        32'h0,        32'h0,        0, 5'd5,  1, 32'h12345678, 32'h12345678, 4'b0000, 32'h0));
    tbl.push_back(mk(1, 0, 0, 2, 32'h100,      32'h0,        32'hDEADBEEF, 3, 5'd7,  1, 32'h0,        32'hDEADBEEF, 4'b0000, 32'h0));
    tbl.push_back(mk(1, 0, 1, 0, 32'h103,      32'h0,        32'h80112233, 1, 5'd8,  1, 32'h0,        32'hFFFFFF80, 4'b0000, 32'h0));
    tbl.push_back(mk(1, 0, 0, 0, 32'h103,      32'h0,        32'h80112233, 2, 5'd9,  1, 32'h0,        32'h00000080, 4'b0000, 32'h0));
    tbl.push_back(mk(0, 1, 0, 1, 32'h202,      32'h0000ABCD, 32'h0,        1, 5'd10, 1, 32'h0,        32'h0,        4'b1100, 32'hABCD0000));
    tbl.push_back(mk(1, 0, 1, 1, 32'h102,      32'h0,        32'h80011234, 1, 5'd11, 1, 32'h0,        32'hFFFF8001, 4'b0000, 32'h0));
    tbl.push_back(mk(1, 1, 1, 0, 32'h301,      32'h000000AA, 32'h00007F00, 2, 5'd12, 1, 32'h0,        32'h0000007F, 4'b0000, 32'h0));
    tbl.push_back(mk(0, 1, 0, 2, 32'h400,      32'hCAFEF00D, 32'h0,        1, 5'd13, 1, 32'h0,        32'h0,        4'b1111, 32'hCAFEF00D));
    tbl.push_back(mk(0, 1, 0, 0, 32'h501,      32'h00000055, 32'h0,        2, 5'd14, 1, 32'h0,        32'h0,        4'b0010, 32'h00005500));
    tbl.push_back(mk(1, 0, 0, 2, 32'h600,      32'h0,        32'h01020304, 1, 5'd15, 0, 32'h0,        32'h01020304, 4'b0000, 32'h0));
    tbl.push_back(mk(0, 0, 0, 2, 32'h0,        32'h0,        32'h0,        0, 5'd31, 0, 32'hA5A5A5A5, 32'hA5A5A5A5, 4'b0000, 32'h0));
    for (int i = 0; i < tbl.size(); i++) run_op(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 2);
      v.sz = 2'($urandom_range(0, 2));
      lo = (v.sz == 2'd0) ? 2'($urandom_range(0, 3)) : ((v.sz == 2'd1) ? {1'($urandom_range(0, 1)), 1'b0} : 2'd0);
      a = $urandom;
      a[1:0] = lo;
      v.addr = a;
      v.rd = (kind == 1);
      v.wr = (kind == 2);
      v.sgn = 1'($urandom_range(0, 1));
      v.data = $urandom;
      v.rdata = $urandom;
      v.delay = $urandom_range(1, 4);
      v.rc_addr = 5'($urandom_range(0, 31));
      v.rc_wr = 1'($urandom_range(0, 1));
      v.rc_data = $urandom;
      v.exp_wb = (kind == 0) ? v.rc_data : extract(v.rdata, v.sz, lo, v.sgn);
      v.exp_strb = (kind == 2) ? mask_for(v.sz, lo) : 4'b0000;
      v.exp_wdata = place(v.data, v.sz, lo);
      run_op(v, $sformatf("rnd%0d", i));
    end

    bus.dmem_ack = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.dmem_ack = 1'b0;
    chk("idle_ack wb_valid", bus.wb_valid, 0);
    chk("idle_ack dmem_req", bus.dmem_req, 0);

    bus.in_valid = 1'b1; bus.readWr = 1'b1; bus.memAddr = 32'h700; bus.rmask = 4'b1111; bus.regcWr = 1'b1;
    @(posedge clk); @(negedge clk);
    n = 0;
    while (bus.dmem_req && n < 400) begin
      n++;
      @(posedge clk); @(negedge clk);
    end
    idle_inputs();
    chk("timeout req_cycles", n, 255);
    chk("timeout wb_valid", bus.wb_valid, 1);
    chk("timeout wb_wr", bus.wb_wr, 0);
    chk("timeout err_o", bus.err_o, 2'b01);
    chk("timeout dmem_req", bus.dmem_req, 0);
    @(posedge clk); @(negedge clk);
    chk("timeout wb_pulse", bus.wb_valid, 0);
    chk("timeout err_sticky", bus.err_o, 2'b01);

    bus.in_valid = 1'b1; bus.readWr = 1'b1; bus.memAddr = 32'h800; bus.rmask = 4'b1111;
    @(posedge clk); @(negedge clk);
    chk("rstwait dmem_req", bus.dmem_req, 1);
    @(posedge clk); @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    #1;
    chk("rstwait req_cleared", bus.dmem_req, 0);
    chk("rstwait err_cleared", bus.err_o, 0);
    chk("rstwait stall", bus.stall_o, 0);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      bus.dmem_ack = (c == 2);
      @(posedge clk); @(negedge clk);
      if (bus.wb_valid || bus.dmem_req) seen++;
    end
    bus.dmem_ack = 1'b0;
    chk("rstwait late_ack_ignored", seen, 0);

`ifdef LSU_MISALIGN_CHECK_EN
    bus.in_valid = 1'b1; bus.readWr = 1'b1; bus.memAddr = 32'h101; bus.rmask = 4'b1110; bus.regcWr = 1'b1;
    @(posedge clk); @(negedge clk);
    seen = bus.dmem_req ? 1 : 0;
    idle_inputs();
    chk("misalign wb_valid", bus.wb_valid, 1);
    chk("misalign wb_wr", bus.wb_wr, 0);
    chk("misalign err_o", bus.err_o, 2'b11);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); @(negedge clk);
      if (bus.dmem_req) seen++;
    end
    chk("misalign no_req", seen, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
